// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the memory loader: FSM state encoding,
// load-mode encodings and default widths.
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

package mem_loader_pkg;

  localparam int ML_DATA_W = `REG_WIDTH;
  localparam int ML_ADDR_W = `ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FILL   = 2'd2,
    DONE   = 2'd3
  } ml_state_t;

  localparam logic LD_MODE_STREAM = 1'b0;
  localparam logic LD_MODE_FILL   = 1'b1;

endpackage

// File: rtl/mem_loader_if.sv
// CPU port, load-control and stream-handshake signals of the memory loader.
// The master side drives requests; the slave side (the loader) answers.
interface mem_loader_if
  import mem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = ML_DATA_W,
  parameter int ADDR_WIDTH = ML_ADDR_W
);

  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;

  logic                  ld_start;
  logic                  ld_mode;
  logic [ADDR_WIDTH-1:0] ld_base;
  logic [ADDR_WIDTH:0]   ld_len;
  logic [DATA_WIDTH-1:0] ld_fill;

  logic                  ld_valid;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_ready;

  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH:0]   ld_count;

  modport master (
    output we, addr, din, ld_start, ld_mode, ld_base, ld_len, ld_fill,
           ld_valid, ld_data,
    input  dout, ld_ready, busy, done, ld_count
  );

  modport slave (
    input  we, addr, din, ld_start, ld_mode, ld_base, ld_len, ld_fill,
           ld_valid, ld_data,
    output dout, ld_ready, busy, done, ld_count
  );

endinterface

// File: rtl/mem_loader_core.sv
// Single-write-port word array with a registered, enable-gated read port.
// Only the read register is reset; array contents survive reset.
module mem_core #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read samples the array before this edge's write lands (read-before-write).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_loader.sv
// Memory with a CPU port and a bulk loader (stream or constant fill).
// The loader owns the array while busy; CPU writes are dropped and dout holds.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = ML_DATA_W,
  parameter int ADDR_WIDTH = ML_ADDR_W
) (
  input  logic         clk,
  input  logic         reset_n,
  mem_loader_if.slave  bus
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  ml_state_t             state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CW-1:0]         len_q;
  logic [DATA_WIDTH-1:0] fill_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;

  logic                  idle;
  logic                  loader_we;
  logic                  ld_last;
  logic [ADDR_WIDTH-1:0] ld_addr;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign idle      = (state_q == IDLE);
  assign loader_we = ((state_q == STREAM) && bus.ld_valid) || (state_q == FILL);
  assign cnt_d     = cnt_q + CNT_ONE;
  assign ld_last   = (cnt_d == len_q);
  // Truncation to ADDR_WIDTH gives the modulo-DEPTH wrap for free.
  assign ld_addr   = base_q + cnt_q[ADDR_WIDTH-1:0];

  assign mem_we    = loader_we || (idle && bus.we);
  assign mem_waddr = idle ? bus.addr : ld_addr;
  assign mem_wdata = idle ? bus.din : ((state_q == FILL) ? fill_q : bus.ld_data);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.ld_start) begin
            base_q <= bus.ld_base;
            len_q  <= bus.ld_len;
            fill_q <= bus.ld_fill;
            cnt_q  <= '0;
            if (bus.ld_len == '0) begin
              state_q <= DONE;
            end else begin
              state_q <= (bus.ld_mode == LD_MODE_STREAM) ? STREAM : FILL;
            end
          end
        end
        STREAM: begin
          if (bus.ld_valid) begin
            cnt_q <= cnt_d;
            if (ld_last) state_q <= DONE;
          end
        end
        FILL: begin
          cnt_q <= cnt_d;
          if (ld_last) state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  mem_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .re_i    (idle),
    .raddr_i (bus.addr),
    .rdata_o (mem_rdata)
  );

  assign bus.dout     = mem_rdata;
  assign bus.ld_ready = (state_q == STREAM);
  assign bus.busy     = !idle;
  assign bus.done     = (state_q == DONE);
  assign bus.ld_count = cnt_q;

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: drivers push expected reads and load
// completions into queues, a negedge monitor pops and compares them.
module tb_mem_loader;
  import mem_loader_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 16;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mem_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  bit            ref_ok  [DEPTH];

  typedef struct { int due; logic [AW-1:0] a; logic [DW-1:0] val; } rd_t;
  typedef struct { int cnt; int busy_cyc; } dn_t;
  rd_t rdq[$];
  dn_t dnq[$];
  logic [DW-1:0] sdata[$];
  int busy_run = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: load completions and scheduled CPU read results.
  always @(negedge clk) begin
    dn_t e;
    rd_t r;
    if (!reset_n) begin
      busy_run = 0;
    end else begin
      if (bus.busy === 1'b1) busy_run++;
      if (bus.done === 1'b1) begin
        if (dnq.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = dnq.pop_front();
          check("ld_count_at_done", bus.ld_count, e.cnt);
          check("busy_cycles", busy_run, e.busy_cyc);
        end
      end
      if (bus.busy !== 1'b1) busy_run = 0;
      while (rdq.size() > 0 && rdq[0].due <= cyc) begin
        r = rdq.pop_front();
        check($sformatf("read_%04h", r.a), bus.dout, r.val);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ref_mem[a] = d;
    ref_ok[a]  = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (bus.busy !== 1'b0) check("wait_idle_timeout", bus.busy, 32'd0);
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wait_idle();
    bus.we = 1'b1; bus.addr = a; bus.din = d;
    if (ref_ok[a]) rdq.push_back('{cyc + 1, a, ref_mem[a]});
    tick();
    bus.we = 1'b0;
    ref_write(a, d);
  endtask

  task automatic cpu_read(input logic [AW-1:0] a);
    wait_idle();
    bus.addr = a;
    if (ref_ok[a]) rdq.push_back('{cyc + 1, a, ref_mem[a]});
    tick();
  endtask

  task automatic readback(input logic [AW-1:0] base, input int len);
    for (int i = 0; i < len; i++) cpu_read(base + AW'(i));
  endtask

  task automatic load_start(input logic mode, input logic [AW-1:0] base, input int len,
                            input logic [DW-1:0] fill, input logic cwe,
                            input logic [AW-1:0] ca, input logic [DW-1:0] cd);
    wait_idle();
    bus.ld_start = 1'b1; bus.ld_mode = mode; bus.ld_base = base;
    bus.ld_len = (AW + 1)'(len); bus.ld_fill = fill;
    bus.we = cwe; bus.addr = ca; bus.din = cd;
    tick();
    bus.ld_start = 1'b0; bus.we = 1'b0;
    if (cwe) ref_write(ca, cd);
  endtask

  task automatic do_fill(input logic [AW-1:0] base, input int len, input logic [DW-1:0] fv,
                         input bit disturb, input logic cwe,
                         input logic [AW-1:0] ca, input logic [DW-1:0] cd);
    load_start(LD_MODE_FILL, base, len, fv, cwe, ca, cd);
    dnq.push_back('{len, len + 1});
    for (int i = 0; i < len; i++) ref_write(base + AW'(i), fv);
    if (disturb) begin
      tick();
      bus.ld_start = 1'b1; bus.ld_mode = LD_MODE_STREAM; bus.ld_fill = ~fv;
      bus.ld_base = base + 16'd100; bus.ld_len = 17'd2;
      bus.we = 1'b1; bus.addr = 16'h0010; bus.din = 8'h55;
      tick();
      bus.ld_start = 1'b0; bus.we = 1'b0;
    end
    wait_idle();
    readback(base, len);
  endtask

  task automatic do_stream(input logic [AW-1:0] base, input int len, input int gap_at,
                           input bit rnd_gaps, input int abort_at);
    int  i = 0;
    int  iters = 0;
    bit  gapped = 1'b0;
    logic v;
    load_start(LD_MODE_STREAM, base, len, 8'h00, 1'b0, 16'h0, 8'h00);
    while (i < len && iters < 500) begin
      if (i == abort_at) begin
        reset_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 32'd0);
        check("abort_done", bus.done, 32'd0);
        check("abort_ld_ready", bus.ld_ready, 32'd0);
        check("abort_ld_count", bus.ld_count, 32'd0);
        check("abort_dout", bus.dout, 32'd0);
        bus.ld_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        return;
      end
      v = rnd_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (i == gap_at && !gapped) begin
        v = 1'b0;
        gapped = 1'b1;
      end
      bus.ld_valid = v;
      bus.ld_data  = sdata[i];
      check("ld_ready_stream", bus.ld_ready, 32'd1);
      tick();
      iters++;
      if (v) begin
        ref_write(base + AW'(i), sdata[i]);
        i++;
      end
    end
    bus.ld_valid = 1'b0;
    dnq.push_back('{len, iters + 1});
    wait_idle();
    readback(base, len);
  endtask

  initial begin
    bus.we = 0; bus.addr = '0; bus.din = '0; bus.ld_start = 0; bus.ld_mode = 0;
    bus.ld_base = '0; bus.ld_len = '0; bus.ld_fill = '0; bus.ld_valid = 0; bus.ld_data = '0;
    reset_n = 1'b0;
    repeat (3) tick();
    check("rst_busy", bus.busy, 32'd0);
    check("rst_done", bus.done, 32'd0);
    check("rst_ld_ready", bus.ld_ready, 32'd0);
    check("rst_ld_count", bus.ld_count, 32'd0);
    check("rst_dout", bus.dout, 32'd0);
    reset_n = 1'b1;
    tick();

    // Directed: stream with a valid gap after the second word.
    sdata = '{8'hA9, 8'h01, 8'h8D, 8'h00};
    do_stream(16'h8000, 4, 2, 1'b0, -1);
    check("ld_count_hold", bus.ld_count, 32'd4);

    // Directed: fill wrapping past the top of the array.
    do_fill(16'hFFFE, 4, 8'hEA, 1'b0, 1'b0, 16'h0, 8'h00);

    // Directed: CPU write and restart attempt while busy are both ignored.
    cpu_write(16'h0010, 8'h33);
    do_fill(16'h0200, 5, 8'h77, 1'b1, 1'b0, 16'h0, 8'h00);
    cpu_read(16'h0010);
    cpu_write(16'h0010, 8'h55);
    cpu_read(16'h0010);

    // Directed: zero-length load leaves memory untouched.
    do_fill(16'h8000, 0, 8'h12, 1'b0, 1'b0, 16'h0, 8'h00);
    cpu_read(16'h8000);

    // Directed: CPU write in the start cycle, then overwritten by the fill.
    do_fill(16'h0300, 3, 8'hC3, 1'b0, 1'b1, 16'h0301, 8'h5A);
    cpu_write(16'h0303, 8'h9E);
    cpu_read(16'h0303);

    // Directed: reset after two of six stream words.
    sdata = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    do_stream(16'h4000, 6, -1, 1'b0, 2);
    readback(16'h4000, 2);
    do_fill(16'h4000, 3, 8'hBD, 1'b0, 1'b0, 16'h0, 8'h00);

    // Randomised mix of CPU accesses and loads.
    for (int k = 0; k < 30; k++) begin
      int op;
      int len;
      logic [AW-1:0] base;
      op   = $urandom_range(0, 3);
      len  = $urandom_range(0, 8);
      base = ($urandom_range(0, 3) == 0) ? (16'hFFF8 + AW'($urandom_range(0, 7)))
                                         : AW'($urandom);
      case (op)
        0: cpu_write(base, DW'($urandom));
        1: begin
          cpu_write(base, DW'($urandom));
          cpu_read(base);
        end
        2: begin
          sdata.delete();
          for (int j = 0; j < len; j++) sdata.push_back(DW'($urandom));
          do_stream(base, len, -1, 1'b1, -1);
        end
        default: do_fill(base, len, DW'($urandom), 1'b0,
                         1'($urandom_range(0, 1)), base, DW'($urandom));
      endcase
    end

    repeat (4) tick();
    check("read_queue_drained", rdq.size(), 32'd0);
    check("done_queue_drained", dnq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
